// File: rtl/ctrl_pkg.sv
// Shared control-word layout for the RV32I decoder and the control pipeline.
// Field indices, ALU op encodings and the per-stage control/register structs.
package ctrl_pkg;

  localparam int unsigned CTRL_WIDTH = 16;

  localparam int unsigned IDX_RSVD_LSB   = 9;
  localparam int unsigned IDX_IS_JAL     = 8;
  localparam int unsigned IDX_ALUOP_MSB  = 7;
  localparam int unsigned IDX_ALUOP_LSB  = 6;
  localparam int unsigned IDX_ALUSRC     = 5;
  localparam int unsigned IDX_IS_BRANCH  = 4;
  localparam int unsigned IDX_MEM_RE     = 3;
  localparam int unsigned IDX_MEM_WE     = 2;
  localparam int unsigned IDX_REG_WR_EN  = 1;
  localparam int unsigned IDX_MEM_TO_REG = 0;

  typedef enum logic [1:0] {
    AluopAdd   = 2'b00,
    AluopSltu  = 2'b01,
    AluopFunct = 2'b10
  } aluop_e;

  typedef struct packed {
    logic reg_wr_en;
    logic is_mem_to_reg;
  } wb_ctrl_t;

  typedef struct packed {
    logic     is_branch;
    logic     mem_re;
    logic     mem_we;
    wb_ctrl_t wb;
  } mem_ctrl_t;

  typedef struct packed {
    logic       is_jal;
    logic [1:0] aluop;
    logic       alusrc;
    mem_ctrl_t  mem;
  } ex_ctrl_t;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    ex_ctrl_t   ctrl;
  } ex_stage_t;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    mem_ctrl_t  ctrl;
  } mem_stage_t;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    wb_ctrl_t   ctrl;
  } wb_stage_t;

endpackage

// File: rtl/hazard_unit.sv
// Load-use hazard detection: a load in EX whose rd feeds the instruction in ID.
module hazard_unit (
  input  logic       ex_valid_i,
  input  logic       ex_mem_re_i,
  input  logic [4:0] ex_rd_i,
  input  logic       id_valid_i,
  input  logic [4:0] id_rs1_i,
  input  logic [4:0] id_rs2_i,
  output logic       hazard_o
);

  always_comb begin
    hazard_o = ex_valid_i & ex_mem_re_i & (ex_rd_i != 5'd0) & id_valid_i &
               ((ex_rd_i == id_rs1_i) | (ex_rd_i == id_rs2_i));
  end

endmodule

// File: rtl/ctrl_pipe.sv
// Carries the decoded control word through EX, MEM and WB, inserting bubbles for
// load-use hazards, branch flushes and data-memory stalls.
module ctrl_pipe
  import ctrl_pkg::*;
#(
  parameter int unsigned CTRL_WIDTH = ctrl_pkg::CTRL_WIDTH
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [CTRL_WIDTH-1:0] i_ctrl,
  input  logic                  i_id_valid,
  input  logic [4:0]            i_id_rd,
  input  logic [4:0]            i_id_rs1,
  input  logic [4:0]            i_id_rs2,
  input  logic                  i_flush,
  input  logic                  i_mem_stall,
  output logic                  o_id_stall,
  output logic                  o_ex_valid,
  output logic                  o_ex_is_jal,
  output logic [1:0]            o_ex_aluop,
  output logic                  o_ex_alusrc,
  output logic [4:0]            o_ex_rd,
  output logic                  o_mem_valid,
  output logic                  o_mem_is_branch,
  output logic                  o_mem_re,
  output logic                  o_mem_we,
  output logic [4:0]            o_mem_rd,
  output logic                  o_wb_valid,
  output logic                  o_wb_reg_wr_en,
  output logic                  o_wb_is_mem_to_reg,
  output logic [4:0]            o_wb_rd
);

  ex_stage_t  ex_q, ex_d, ex_in;
  mem_stage_t mem_q, mem_d;
  wb_stage_t  wb_q, wb_d;
  logic       flush_pend_q, flush_pend_d;
  logic       hazard, flush_eff;
  logic       unused_rsvd;

  assign unused_rsvd = ^i_ctrl[CTRL_WIDTH-1:IDX_RSVD_LSB];

  hazard_unit u_hazard_unit (
    .ex_valid_i  (ex_q.valid),
    .ex_mem_re_i (ex_q.ctrl.mem.mem_re),
    .ex_rd_i     (ex_q.rd),
    .id_valid_i  (i_id_valid),
    .id_rs1_i    (i_id_rs1),
    .id_rs2_i    (i_id_rs2),
    .hazard_o    (hazard)
  );

  // A flush seen while memory is stalled is held until the stall releases.
  assign flush_eff  = (i_flush | flush_pend_q) & ~i_mem_stall;
  assign o_id_stall = i_mem_stall | (hazard & ~flush_eff);

  always_comb begin
    ex_in                        = '0;
    ex_in.valid                  = 1'b1;
    ex_in.rd                     = i_id_rd;
    ex_in.ctrl.is_jal            = i_ctrl[IDX_IS_JAL];
    ex_in.ctrl.aluop             = i_ctrl[IDX_ALUOP_MSB:IDX_ALUOP_LSB];
    ex_in.ctrl.alusrc            = i_ctrl[IDX_ALUSRC];
    ex_in.ctrl.mem.is_branch     = i_ctrl[IDX_IS_BRANCH];
    ex_in.ctrl.mem.mem_re        = i_ctrl[IDX_MEM_RE];
    ex_in.ctrl.mem.mem_we        = i_ctrl[IDX_MEM_WE];
    ex_in.ctrl.mem.wb.reg_wr_en  = i_ctrl[IDX_REG_WR_EN];
    ex_in.ctrl.mem.wb.is_mem_to_reg = i_ctrl[IDX_MEM_TO_REG];
  end

  always_comb begin
    ex_d         = ex_q;
    mem_d        = mem_q;
    wb_d         = wb_q;
    flush_pend_d = flush_pend_q;
    if (i_mem_stall) begin
      // EX and MEM freeze; WB takes a bubble so nothing writes back twice.
      wb_d         = '0;
      flush_pend_d = flush_pend_q | i_flush;
    end else begin
      flush_pend_d = 1'b0;
      mem_d.valid  = ex_q.valid;
      mem_d.rd     = ex_q.rd;
      mem_d.ctrl   = ex_q.ctrl.mem;
      wb_d.valid   = mem_q.valid;
      wb_d.rd      = mem_q.rd;
      wb_d.ctrl    = mem_q.ctrl.wb;
      if (flush_eff || hazard || !i_id_valid) begin
        ex_d = '0;
      end else begin
        ex_d = ex_in;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ex_q         <= '0;
      mem_q        <= '0;
      wb_q         <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      ex_q         <= ex_d;
      mem_q        <= mem_d;
      wb_q         <= wb_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  assign o_ex_valid         = ex_q.valid;
  assign o_ex_is_jal        = ex_q.ctrl.is_jal;
  assign o_ex_aluop         = ex_q.ctrl.aluop;
  assign o_ex_alusrc        = ex_q.ctrl.alusrc;
  assign o_ex_rd            = ex_q.rd;
  assign o_mem_valid        = mem_q.valid;
  assign o_mem_is_branch    = mem_q.ctrl.is_branch;
  assign o_mem_re           = mem_q.ctrl.mem_re;
  assign o_mem_we           = mem_q.ctrl.mem_we;
  assign o_mem_rd           = mem_q.rd;
  assign o_wb_valid         = wb_q.valid;
  assign o_wb_reg_wr_en     = wb_q.ctrl.reg_wr_en;
  assign o_wb_is_mem_to_reg = wb_q.ctrl.is_mem_to_reg;
  assign o_wb_rd            = wb_q.rd;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Directed bench for ctrl_pipe: a vector table for the steady-state pipe plus
// hand-written sequences for memory stall, deferred flush and async reset.
module tb_ctrl_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] ctrl;
  logic        id_valid, flush, mem_stall;
  logic [4:0]  id_rd, id_rs1, id_rs2;
  logic        id_stall;
  logic        ex_valid, ex_is_jal, ex_alusrc;
  logic [1:0]  ex_aluop;
  logic [4:0]  ex_rd, mem_rd, wb_rd;
  logic        mem_valid, mem_is_branch, mem_re, mem_we;
  logic        wb_valid, wb_reg_wr_en, wb_is_mem_to_reg;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ctrl_pipe #(.CTRL_WIDTH(16)) dut (
    .i_clk              (clk),
    .i_rst_n            (rst_n),
    .i_ctrl             (ctrl),
    .i_id_valid         (id_valid),
    .i_id_rd            (id_rd),
    .i_id_rs1           (id_rs1),
    .i_id_rs2           (id_rs2),
    .i_flush            (flush),
    .i_mem_stall        (mem_stall),
    .o_id_stall         (id_stall),
    .o_ex_valid         (ex_valid),
    .o_ex_is_jal        (ex_is_jal),
    .o_ex_aluop         (ex_aluop),
    .o_ex_alusrc        (ex_alusrc),
    .o_ex_rd            (ex_rd),
    .o_mem_valid        (mem_valid),
    .o_mem_is_branch    (mem_is_branch),
    .o_mem_re           (mem_re),
    .o_mem_we           (mem_we),
    .o_mem_rd           (mem_rd),
    .o_wb_valid         (wb_valid),
    .o_wb_reg_wr_en     (wb_reg_wr_en),
    .o_wb_is_mem_to_reg (wb_is_mem_to_reg),
    .o_wb_rd            (wb_rd)
  );

  wire [9:0] ex_obs  = {ex_valid, ex_is_jal, ex_aluop, ex_alusrc, ex_rd};
  wire [8:0] mem_obs = {mem_valid, mem_is_branch, mem_re, mem_we, mem_rd};
  wire [7:0] wb_obs  = {wb_valid, wb_reg_wr_en, wb_is_mem_to_reg, wb_rd};

  function automatic logic [9:0] exw(input logic v, input logic j, input logic [1:0] op,
                                     input logic s, input logic [4:0] rd);
    return {v, j, op, s, rd};
  endfunction

  function automatic logic [8:0] memw(input logic v, input logic br, input logic re,
                                      input logic we, input logic [4:0] rd);
    return {v, br, re, we, rd};
  endfunction

  function automatic logic [7:0] wbw(input logic v, input logic wr, input logic m2r,
                                     input logic [4:0] rd);
    return {v, wr, m2r, rd};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_stages(input string name, input logic [9:0] e_ex,
                            input logic [8:0] e_mem, input logic [7:0] e_wb);
    chk({name, " ex"}, 32'(ex_obs), 32'(e_ex));
    chk({name, " mem"}, 32'(mem_obs), 32'(e_mem));
    chk({name, " wb"}, 32'(wb_obs), 32'(e_wb));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [15:0] c, input logic v, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic fl,
                       input logic ms);
    ctrl = c; id_valid = v; id_rd = rd; id_rs1 = rs1; id_rs2 = rs2;
    flush = fl; mem_stall = ms;
    #1;
  endtask

  typedef struct {
    logic [15:0] ctrl;
    logic        vld;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        flush;
    logic        mstall;
    logic        exp_stall;
    logic [9:0]  exp_ex;
    logic [8:0]  exp_mem;
    logic [7:0]  exp_wb;
  } vec_t;

  localparam logic [15:0] LOAD = 16'h000B;
  localparam logic [15:0] RTYP = 16'h0082;
  localparam logic [15:0] JAL  = 16'h0102;
  localparam logic [15:0] STOR = 16'h0024;
  localparam logic [15:0] BRCH = 16'h0050;
  localparam logic [15:0] RSVD = 16'hFE00;

  vec_t vecs[12];

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench timed out");
  end

  initial begin
    vecs[0]  = '{LOAD, 1, 5, 1, 2, 0, 0, 0, exw(1,0,0,0,5), '0, '0};
    vecs[1]  = '{RTYP, 1, 6, 5, 0, 0, 0, 1, '0, memw(1,0,1,0,5), '0};
    vecs[2]  = '{RTYP, 1, 6, 5, 0, 0, 0, 0, exw(1,0,2,0,6), '0, wbw(1,1,1,5)};
    vecs[3]  = '{LOAD, 1, 0, 0, 0, 0, 0, 0, exw(1,0,0,0,0), memw(1,0,0,0,6), '0};
    vecs[4]  = '{RTYP, 1, 7, 0, 0, 0, 0, 0, exw(1,0,2,0,7), memw(1,0,1,0,0), wbw(1,1,0,6)};
    vecs[5]  = '{RSVD, 1, 9, 3, 4, 0, 0, 0, exw(1,0,0,0,9), memw(1,0,0,0,7), wbw(1,1,1,0)};
    vecs[6]  = '{RTYP, 0, 10, 0, 0, 0, 0, 0, '0, memw(1,0,0,0,9), wbw(1,1,0,7)};
    vecs[7]  = '{JAL, 1, 1, 0, 0, 0, 0, 0, exw(1,1,0,0,1), '0, wbw(1,0,0,9)};
    vecs[8]  = '{STOR, 1, 0, 0, 0, 1, 0, 0, '0, memw(1,0,0,0,1), '0};
    vecs[9]  = '{BRCH, 1, 0, 2, 3, 0, 0, 0, exw(1,0,1,0,0), '0, wbw(1,1,0,1)};
    vecs[10] = '{STOR, 1, 11, 0, 0, 0, 0, 0, exw(1,0,0,1,11), memw(1,1,0,0,0), '0};
    vecs[11] = '{16'h0, 0, 0, 0, 0, 0, 0, 0, '0, memw(1,0,0,1,11), wbw(1,0,0,0)};

    rst_n = 1'b0;
    drive(16'h0, 0, 0, 0, 0, 0, 0);
    #1;
    chk_stages("reset", '0, '0, '0);
    chk("reset stall", 32'(id_stall), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].ctrl, vecs[i].vld, vecs[i].rd, vecs[i].rs1, vecs[i].rs2,
            vecs[i].flush, vecs[i].mstall);
      chk($sformatf("row%0d stall", i), 32'(id_stall), 32'(vecs[i].exp_stall));
      tick();
      chk_stages($sformatf("row%0d", i), vecs[i].exp_ex, vecs[i].exp_mem, vecs[i].exp_wb);
    end

    // Fill the pipe, then hold a memory stall for three cycles with a flush in the middle.
    drive(LOAD, 1, 3, 1, 2, 0, 0);
    tick();
    chk_stages("fill load", exw(1,0,0,0,3), '0, wbw(1,0,0,11));
    drive(RTYP, 1, 4, 1, 2, 0, 0);
    chk("fill r stall", 32'(id_stall), 32'd0);
    tick();
    drive(STOR, 1, 12, 0, 0, 0, 0);
    tick();
    chk_stages("fill store", exw(1,0,0,1,12), memw(1,0,0,0,4), wbw(1,1,1,3));
    for (int c = 1; c <= 3; c++) begin
      drive(RTYP, 1, 8, 3, 0, (c == 2), 1);
      chk($sformatf("mstall%0d stall", c), 32'(id_stall), 32'd1);
      tick();
      chk_stages($sformatf("mstall%0d", c), exw(1,0,0,1,12), memw(1,0,0,0,4), '0);
    end
    drive(RTYP, 1, 8, 3, 0, 0, 0);
    chk("release stall", 32'(id_stall), 32'd0);
    tick();
    chk_stages("release", '0, memw(1,0,0,1,12), wbw(1,1,0,4));
    tick();
    chk_stages("after release", exw(1,0,2,0,8), '0, wbw(1,0,0,12));

    // Async reset while a flush is pending; the pipe must restart empty with no stale flush.
    drive(RTYP, 1, 8, 3, 0, 1, 1);
    tick();
    #2;
    rst_n = 1'b0;
    drive(16'h0, 0, 0, 0, 0, 0, 0);
    chk_stages("async reset", '0, '0, '0);
    chk("async reset stall", 32'(id_stall), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(RTYP, 1, 13, 0, 0, 0, 0);
    tick();
    chk_stages("post reset", exw(1,0,2,0,13), '0, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ctrl_pipe.md
# ctrl_pipe

Control-word pipeline carrying the packed decode control word from the ID stage through EX, MEM and WB. It registers the word once per stage and presents each stage's control fields as discrete outputs. It also generates the load-use stall and applies bubbles for hazards, flushes and memory stalls. It sits between the opcode decoder and the datapath pipeline registers of the RV32I core.

## Interface
Parameters:
- CTRL_WIDTH, 16, width of packed control word; layout fixed, bits [15:9] reserved.

Ports:
- i_clk  input  1  core clock; all state updates on rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_ctrl  input  CTRL_WIDTH  packed control word from decoder: [8] is_jal, [7:6] aluop, [5] alusrc, [4] is_branch, [3] mem_re, [2] mem_we, [1] reg_wr_en, [0] is_mem_to_reg.
- i_id_valid  input  1  ID stage holds a real instruction.
- i_id_rd, i_id_rs1, i_id_rs2  input  5 each  register indices of ID instruction.
- i_flush  input  1  taken branch/jump resolved in EX; kill ID instruction.
- i_mem_stall  input  1  data memory not ready; freeze EX and MEM.
- o_id_stall  output  1  hold PC and IF/ID register this cycle (combinational).
- o_ex_valid, o_ex_is_jal, o_ex_aluop[1:0], o_ex_alusrc, o_ex_rd[4:0]  output  EX-stage fields.
- o_mem_valid, o_mem_is_branch, o_mem_re, o_mem_we, o_mem_rd[4:0]  output  MEM-stage fields.
- o_wb_valid, o_wb_reg_wr_en, o_wb_is_mem_to_reg, o_wb_rd[4:0]  output  WB-stage fields.

## Operation
- Three stage registers (EX, MEM, WB), each holding valid, rd and the control bits used from that stage onward.
- Bubble = valid 0, all control bits 0, rd 0. Reserved bits [15:9] are dropped at EX entry.
- Load-use hazard: o_ex_valid & o_ex_mem_re (registered [3]) & o_ex_rd != 0 & i_id_valid & (o_ex_rd == i_id_rs1 | o_ex_rd == i_id_rs2).
- o_id_stall = i_mem_stall | (hazard & ~flush_eff).
- flush_eff = (i_flush | flush_pend) & ~i_mem_stall.
- Per-cycle priority:
  - i_mem_stall: EX and MEM hold; WB loads bubble (no repeated writeback). An i_flush seen this cycle sets flush_pend.
  - else flush_eff: EX loads bubble, MEM<-EX, WB<-MEM; flush_pend cleared.
  - else hazard: EX loads bubble, MEM<-EX, WB<-MEM.
  - else: EX<-{i_id_valid, i_ctrl fields, i_id_rd} (bubble if i_id_valid=0), MEM<-EX, WB<-MEM.
- Writes with rd 0 propagate unchanged; the regfile ignores them.

## Timing
- Reset: all outputs 0, flush_pend 0, asserted asynchronously; release is synchronous to i_clk.
- Latency: word accepted at edge N is visible on EX outputs after N, on MEM outputs after N+1, on WB outputs after N+2. No combinational path from i_ctrl to any output.
- o_id_stall is combinational from i_mem_stall, i_flush, ID indices and the EX register. It is the only combinational output.
- Load-use costs exactly one bubble: the stall drops the cycle after the load moves to MEM.
- Flush during mem stall is deferred, never lost; multiple flushes while stalled collapse into one.
- Reset mid-stall: pending flush discarded; pipe restarts empty.

## Structure
- Package ctrl_pkg: CTRL_WIDTH, bit-index constants for every field, aluop encodings (ADD 00, SLTU 01, FUNCT 10), and stage struct typedefs ex_ctrl_t, mem_ctrl_t, wb_ctrl_t. The decoder imports the same package.
- One sub-module, hazard_unit: pure combinational load-use detect. All stage registers stay in ctrl_pipe.

## Test plan
- Reset then LOAD word 0x000B with rd 5 → EX outputs show mem_re=1 after 1 edge; o_wb_reg_wr_en=1, o_wb_is_mem_to_reg=1, o_wb_rd=5 after 3 edges.
- LOAD rd 5 followed by R-type with rs1=5 → o_id_stall=1 for exactly 1 cycle; one bubble (o_mem_valid=0) appears behind the load.
- Same as above but rd=0 → no stall.
- i_flush with JAL in EX → next EX valid=0; JAL continues to WB with reg_wr_en=1.
- i_mem_stall held 3 cycles with i_flush pulsed in cycle 2 → EX/MEM frozen, WB valid=0 for 3 cycles, then a single EX bubble on release.
- i_ctrl=0xFE00 (reserved bits only), valid=1 → EX valid=1 with all control outputs 0.
- Assert i_rst_n low mid-stream → all outputs 0 immediately, without waiting for a clock edge.
